// File: rtl/mpc_constraint_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port constraint RAM.
// After reset or clr, the RAM is swept to zero, then A/B accesses are served one per cycle.
module mpc_constraint_ram_arbiter #(
  parameter int DataWidth    = 21,
  parameter int AddressWidth = 3,
  parameter int AddressRange = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    req_a,
  input  logic                    req_b,
  input  logic                    we_a,
  input  logic                    we_b,
  input  logic [AddressWidth-1:0] addr_a,
  input  logic [AddressWidth-1:0] addr_b,
  input  logic [DataWidth-1:0]    wdata_a,
  input  logic [DataWidth-1:0]    wdata_b,
  output logic                    gnt_a,
  output logic                    gnt_b,
  output logic                    rvalid_a,
  output logic                    rvalid_b,
  output logic [DataWidth-1:0]    rdata,
  output logic                    err,
  output logic [AddressWidth-1:0] ram_address0,
  output logic                    ram_ce0,
  output logic                    ram_we0,
  output logic [DataWidth-1:0]    ram_d0,
  input  logic [DataWidth-1:0]    ram_q0
);

  typedef enum logic {CLEAR, SERVE} state_e;

  localparam logic [AddressWidth-1:0] LastIdx = AddressWidth'(AddressRange - 1);
  localparam logic [AddressWidth:0]   RangeW  = (AddressWidth + 1)'(AddressRange);

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] cnt_q, cnt_d;
  logic                    last_b_q, last_b_d;
  logic                    err_q, err_d;
  logic                    rvalid_a_q, rvalid_a_d;
  logic                    rvalid_b_q, rvalid_b_d;
  logic                    oor_q, oor_d;

  logic [AddressWidth-1:0] sel_addr;
  logic                    sel_we;
  logic [DataWidth-1:0]    sel_wdata;
  logic                    any_gnt;
  logic                    in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      last_b_q   <= 1'b1;
      err_q      <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_b_q   <= last_b_d;
      err_q      <= err_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      oor_q      <= oor_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_b_d     = last_b_q;
    err_d        = err_q;
    rvalid_a_d   = 1'b0;
    rvalid_b_d   = 1'b0;
    oor_d        = 1'b0;
    busy         = 1'b0;
    gnt_a        = 1'b0;
    gnt_b        = 1'b0;
    ram_ce0      = 1'b0;
    ram_we0      = 1'b0;
    ram_address0 = '0;
    ram_d0       = '0;
    sel_addr     = '0;
    sel_we       = 1'b0;
    sel_wdata    = '0;
    any_gnt      = 1'b0;
    in_range     = 1'b0;
    unique case (state_q)
      CLEAR: begin
        busy         = 1'b1;
        ram_ce0      = 1'b1;
        ram_we0      = 1'b1;
        ram_address0 = cnt_q;
        if (cnt_q == LastIdx) begin
          state_d = SERVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AddressWidth'(1);
        end
      end
      SERVE: begin
        // A wins a tie only when B was the last one served.
        gnt_a     = req_a && (!req_b || last_b_q);
        gnt_b     = req_b && !gnt_a;
        any_gnt   = gnt_a || gnt_b;
        sel_addr  = gnt_a ? addr_a : addr_b;
        sel_we    = gnt_a ? we_a : we_b;
        sel_wdata = gnt_a ? wdata_a : wdata_b;
        in_range  = {1'b0, sel_addr} < RangeW;
        if (any_gnt) begin
          last_b_d     = gnt_b;
          ram_address0 = sel_addr;
          ram_d0       = sel_wdata;
          rvalid_a_d   = gnt_a && !we_a;
          rvalid_b_d   = gnt_b && !we_b;
          oor_d        = !in_range && !sel_we;
          if (in_range) begin
            ram_ce0 = 1'b1;
            ram_we0 = sel_we;
          end else begin
            err_d = 1'b1;
          end
        end
        // clr takes priority over an error raised by the same cycle's access.
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign err      = err_q;
  assign rdata    = oor_q ? '0 : ram_q0;

endmodule

// File: tb/tb_mpc_constraint_ram_arbiter.sv
// Bench for mpc_constraint_ram_arbiter: directed scenarios plus random traffic,
// checked each cycle against a behavioural model of memory contents and arbitration.
module tb_mpc_constraint_ram_arbiter;
  localparam int DW = 21;
  localparam int AW = 3;
  localparam int AR = 6;

  logic          clk = 1'b0;
  logic          reset, clr, busy;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_address0;
  logic          ram_ce0, ram_we0;
  logic [DW-1:0] ram_d0, ram_q0;

  int tests = 0;
  int fails = 0;

  mpc_constraint_ram_arbiter #(.DataWidth(DW), .AddressWidth(AW), .AddressRange(AR)) dut (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata), .err(err), .ram_address0(ram_address0), .ram_ce0(ram_ce0),
    .ram_we0(ram_we0), .ram_d0(ram_d0), .ram_q0(ram_q0)
  );

  always #5 clk = ~clk;

  // Read-first single-port RAM; scramble fills it with garbage so the sweep is visible.
  logic          scramble;
  logic [DW-1:0] env_mem [0:7];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 8; i++) env_mem[i] <= DW'($urandom);
      ram_q0 <= DW'($urandom);
    end else if (ram_ce0) begin
      ram_q0 <= env_mem[ram_address0];
      if (ram_we0) env_mem[ram_address0] <= ram_d0;
    end
  end

  // Reference model state
  bit            m_clear, m_last_b, m_err, m_rva, m_rvb;
  int            m_idx;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [0:AR-1];

  task automatic model_reset();
    m_clear  = 1'b1;
    m_idx    = 0;
    m_last_b = 1'b1;
    m_err    = 1'b0;
    m_rva    = 1'b0;
    m_rvb    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req_a = 0; req_b = 0; we_a = 0; we_b = 0; clr = 0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
  endtask

  task automatic set_a(input bit r, input bit w, input int a, input logic [DW-1:0] d);
    req_a = r; we_a = w; addr_a = AW'(a); wdata_a = d;
  endtask

  task automatic set_b(input bit r, input bit w, input int a, input logic [DW-1:0] d);
    req_b = r; we_b = w; addr_b = AW'(a); wdata_b = d;
  endtask

  // One clock cycle: check outputs mid-cycle, optionally assert reset, advance model.
  task automatic step(input bit rst_mid);
    bit            ea, eb, gnt, inr, swe;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    #2;
    ea = 0; eb = 0; gnt = 0; inr = 0; swe = 0; sa = '0; sd = '0;
    chk("rvalid_a", rvalid_a, m_rva);
    chk("rvalid_b", rvalid_b, m_rvb);
    chk("err", err, m_err);
    if (m_rva || m_rvb) chk("rdata", rdata, m_rdata);
    if (m_clear) begin
      chk("busy_clr", busy, 1);
      chk("gnt_a_clr", gnt_a, 0);
      chk("gnt_b_clr", gnt_b, 0);
      chk("ce_clr", ram_ce0, 1);
      chk("we_clr", ram_we0, 1);
      chk("addr_clr", ram_address0, m_idx);
      chk("d_clr", ram_d0, 0);
    end else begin
      if (req_a && req_b) begin
        ea = m_last_b;
        eb = !m_last_b;
      end else begin
        ea = req_a;
        eb = req_b;
      end
      gnt = ea || eb;
      sa  = ea ? addr_a : addr_b;
      swe = ea ? we_a : we_b;
      sd  = ea ? wdata_a : wdata_b;
      inr = gnt && (int'(sa) < AR);
      chk("busy_srv", busy, 0);
      chk("gnt_a", gnt_a, ea);
      chk("gnt_b", gnt_b, eb);
      chk("ce", ram_ce0, inr);
      chk("we", ram_we0, inr && swe);
      if (inr) begin
        chk("addr", ram_address0, sa);
        chk("d", ram_d0, sd);
      end
    end
    if (rst_mid) begin
      reset = 1'b1;
      #1;
      model_reset();
      chk("rst_busy", busy, 1);
      chk("rst_gnt", {gnt_a, gnt_b}, 0);
      chk("rst_ce_we", {ram_ce0, ram_we0}, 2'b11);
      chk("rst_addr", ram_address0, 0);
      chk("rst_d", ram_d0, 0);
      chk("rst_rvalid", {rvalid_a, rvalid_b}, 0);
      chk("rst_err", err, 0);
    end
    if (reset) begin
      model_reset();
      m_mem[0] = '0;
    end else if (m_clear) begin
      m_mem[m_idx] = '0;
      m_rva = 0;
      m_rvb = 0;
      m_idx++;
      if (m_idx == AR) begin
        m_clear = 0;
        m_idx   = 0;
      end
    end else begin
      m_rva = ea && !swe;
      m_rvb = eb && !swe;
      if (gnt) begin
        m_last_b = eb;
        if (inr) begin
          if (swe) m_mem[sa] = sd;
          else m_rdata = m_mem[sa];
        end else begin
          m_err   = 1'b1;
          m_rdata = '0;
        end
      end
      if (clr) begin
        m_clear = 1;
        m_idx   = 0;
        m_err   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    scramble = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    scramble = 1'b0;
    step(0);
    step(0);

    // Power-up sweep, then a read of address 3 returns zero
    reset = 1'b0;
    repeat (AR) step(0);
    set_a(1, 0, 3, '0);
    step(0);
    idle();
    step(0);

    // Write from A then read back from B
    set_a(1, 1, 2, 21'h1ABCD);
    step(0);
    idle();
    set_b(1, 0, 2, '0);
    step(0);
    idle();
    step(0);

    // Contention: both read for four cycles, A,B,A,B
    set_a(1, 0, 0, '0);
    set_b(1, 0, 1, '0);
    repeat (4) step(0);
    idle();
    step(0);

    // Out-of-range read, sticky err, clr, full readback
    set_b(1, 0, 7, '0);
    step(0);
    idle();
    repeat (3) step(0);
    clr = 1;
    step(0);
    clr = 0;
    repeat (AR) step(0);
    for (int i = 0; i < AR; i++) begin
      set_a(1, 0, i, '0);
      step(0);
    end
    idle();
    step(0);

    // clr together with a write, requests blocked in sweep, second clr ignored
    set_a(1, 1, 1, 21'h00055);
    clr = 1;
    step(0);
    clr = 0;
    set_a(1, 0, 1, '0);
    set_b(1, 0, 2, '0);
    step(0);
    step(0);
    clr = 1;
    step(0);
    clr = 0;
    repeat (3) step(0);
    chk("sweep_done", busy, 0);
    idle();
    set_a(1, 0, 1, '0);
    step(0);
    idle();
    step(0);

    // Reset at sweep step 3, then reset in the middle of a granted read
    clr = 1;
    step(0);
    clr = 0;
    repeat (3) step(0);
    step(1);
    step(0);
    reset = 1'b0;
    repeat (AR) step(0);
    set_a(1, 0, 4, '0);
    step(1);
    idle();
    step(0);
    reset = 1'b0;
    repeat (AR) step(0);
    step(0);

    // Random traffic
    repeat (600) begin
      reset  = 1'b0;
      req_a  = ($urandom_range(0, 3) != 0);
      req_b  = ($urandom_range(0, 3) != 0);
      we_a   = $urandom_range(0, 1);
      we_b   = $urandom_range(0, 1);
      addr_a = AW'($urandom_range(0, 7));
      addr_b = AW'($urandom_range(0, 7));
      wdata_a = DW'($urandom);
      wdata_b = DW'($urandom);
      clr    = ($urandom_range(0, 24) == 0);
      step($urandom_range(0, 79) == 0);
    end
    reset = 1'b0;
    idle();
    step(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mpc_constraint_ram_arbiter.md
MPC_CONSTRAINT_RAM_ARBITER -- requirements
Module: mpc_constraint_ram_arbiter

Interface
REQ-001 The block SHALL have parameter DataWidth, default 21, which sets the RAM word width.
REQ-002 The block SHALL have parameter AddressWidth, default 3, which sets the RAM address width.
REQ-003 The block SHALL have parameter AddressRange, default 6, which sets the number of valid RAM entries.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 clr  in  1  single-cycle request to zero the whole RAM and clear err.
REQ-007 busy  out  1  high while the clear sweep runs.
REQ-008 req_a / req_b  in  1  access request from requester A (constraint builder) / B (solver).
REQ-009 we_a / we_b  in  1  1 = write, 0 = read; qualified by req_x.
REQ-010 addr_a / addr_b  in  AddressWidth  target word.
REQ-011 wdata_a / wdata_b  in  DataWidth  write data.
REQ-012 gnt_a / gnt_b  out  1  combinational grant; the request completes in the cycle gnt_x is high.
REQ-013 rvalid_a / rvalid_b  out  1  read data valid, one cycle after the read grant.
REQ-014 rdata  out  DataWidth  read data shared by both requesters; qualified by rvalid_x.
REQ-015 err  out  1  sticky flag: an out-of-range address was granted.
REQ-016 ram_address0 / ram_ce0 / ram_we0 / ram_d0  out  RAM port, driven combinationally.
REQ-017 ram_q0  in  DataWidth  RAM read data; read-first, one-cycle latency.

Function
REQ-018 The block SHALL have two states, CLEAR and SERVE.
REQ-019 CLEAR SHALL drive ram_ce0=1, ram_we0=1 and ram_d0=0, with ram_address0 taken from a sweep counter stepping 0..AddressRange-1.
REQ-020 CLEAR SHALL last exactly AddressRange cycles (6 by default) and then enter SERVE; busy=1 throughout CLEAR and 0 in SERVE.
REQ-021 During CLEAR, gnt_a=gnt_b=0 regardless of requests.
REQ-022 clr sampled high in SERVE SHALL enter CLEAR on the next cycle with the counter at 0 and SHALL clear err.
REQ-023 clr sampled high during CLEAR SHALL be ignored; the sweep neither restarts nor extends.
REQ-024 A request arriving in the same cycle as clr in SERVE SHALL still be granted and performed that cycle.
REQ-025 In SERVE, at most one grant per cycle; gnt_x=1 SHALL imply req_x=1.
REQ-026 A single requester SHALL be granted immediately.
REQ-027 When both requesters ask in the same cycle, the one not served last SHALL be granted (round-robin).
REQ-028 The round-robin last-served pointer SHALL update only on a grant, and it resets to "B served last", so A wins the first tie.
REQ-029 A granted request with addr < AddressRange SHALL drive ram_ce0=1, ram_we0=we_x, ram_address0=addr_x and ram_d0=wdata_x.
REQ-030 A granted request with addr >= AddressRange SHALL drive ram_ce0=0 and set err on the next edge.
REQ-031 A granted read SHALL pulse rvalid_x for exactly one cycle, in the following cycle, with rdata=ram_q0.
REQ-032 For an out-of-range read, rdata SHALL be forced to 0 in the rvalid_x cycle.
REQ-033 Granted writes SHALL produce no rvalid.
REQ-034 With no grant, ram_ce0=0 and ram_we0=0 in SERVE.
REQ-035 Back-to-back grants SHALL be supported every cycle, with no bubble between accesses.

Reset
REQ-036 Asserting reset SHALL immediately put the block in state CLEAR with sweep counter 0, pointer "B last", err=0 and rvalid_a=rvalid_b=0.
REQ-037 While reset is high, outputs SHALL be busy=1, gnt_a=gnt_b=0, ram_ce0=1, ram_we0=1, ram_address0=0 and ram_d0=0.
REQ-038 After reset deasserts, a full 6-cycle sweep SHALL run before the first grant.
REQ-039 A reset asserted mid-sweep or mid-access SHALL abort the operation; no rvalid follows, and the sweep restarts from 0.

Verification
REQ-040 Power-up: release reset -> busy=1 for 6 cycles with ram_address0 = 0,1,2,3,4,5 and we=1, d=0; then busy=0, and a read of addr 3 from A returns rdata=0 with rvalid_a one cycle after gnt_a.
REQ-041 Write/read: A writes 0x1ABCD to addr 2, next cycle B reads addr 2 -> gnt_b at once, rvalid_b one cycle later with rdata=0x1ABCD.
REQ-042 Contention: req_a=req_b=1 held for 4 cycles, both reads -> grants A,B,A,B; each rvalid lands on the matching requester one cycle after its grant.
REQ-043 Out-of-range: B reads addr 7 -> gnt_b=1, ram_ce0=0, rvalid_b next cycle with rdata=0, and err=1 until clr; after clr, err=0 and all words read back as 0.
REQ-044 Clear interaction: clr pulsed in SERVE together with an A write of 0x00055 to addr 1 -> write performed, then a 6-cycle sweep with grants blocked, and addr 1 reads 0 afterwards; a second clr mid-sweep -> sweep still ends at cycle 6.
REQ-045 Reset mid-sweep: assert reset at sweep step 3 -> ram_address0=0 at once; after release, a full 6-cycle sweep runs, and no pending rvalid is ever issued.
